// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared types, response codes and helpers for the AXI SRAM slave
package axi_sram_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_CAP  = 3'd2,
      ST_RD_RESP = 3'd3,
      ST_WR_DATA = 3'd4,
      ST_WR_MEM  = 3'd5,
      ST_WR_RESP = 3'd6
   } state_t;

   // Byte step for sub-word transfers (size 0 -> 1 byte, size 1 -> 2 bytes).
   function automatic logic [2:0] narrow_step(input logic [2:0] size);
      return (size == 3'd0) ? 3'd1 : 3'd2;
   endfunction

   // Transfers wider than the 32-bit data bus are answered with SLVERR.
   function automatic logic size_err(input logic [2:0] size);
      return size > 3'd2;
   endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI3 read/write channel bundle with master and slave views
interface axi_sram_slave_if #(
   parameter int ID_W = 4
);
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [3:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [3:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awvalid;
   logic            awready;

   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );
endinterface

// File: rtl/axi_sram_slave_burst_addr.sv
// rtl/axi_sram_slave_burst_addr.sv - INCR burst next-address and SRAM word-address computation
module axi_sram_slave_burst_addr
   import axi_sram_slave_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W+1:0] byte_addr,
   input  logic [2:0]        size,
   output logic [ADDR_W+1:0] next_byte_addr,
   output logic [ADDR_W-1:0] word_addr
);
   logic [ADDR_W-1:0] word_inc;

   assign word_addr = byte_addr[ADDR_W+1:2];
   assign word_inc  = word_addr + ADDR_W'(1);

   // Full-word (and oversize) beats step one aligned word; narrow beats step bytes so that
   // several beats may land in the same word. The width of byte_addr gives the wrap for free.
   always_comb begin
      if (size >= 3'd2) begin
         next_byte_addr = {word_inc, 2'b00};
      end else begin
         next_byte_addr = byte_addr + (ADDR_W+2)'(narrow_step(size));
      end
   end
endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI3 slave turning bursts into 1-cycle-latency SRAM accesses
module axi_sram_slave
   import axi_sram_slave_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   axi_sram_slave_if.slave   bus,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   state_t            state, next_state;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W+1:0] addr_q, next_addr;
   logic [ADDR_W-1:0] word_addr;
   logic [3:0]        len_q, beat_q;
   logic [2:0]        size_q;
   logic              err_q, wr_done_q;
   logic [31:0]       rdata_q, wdata_q;
   logic [3:0]        wstrb_q;
   logic              aw_hs, ar_hs, w_hs, r_hs, last_beat;
   logic              unused_bits;

   assign unused_bits = ^{bus.araddr[31:ADDR_W+2], bus.awaddr[31:ADDR_W+2], bus.arburst, bus.awburst};

   axi_sram_slave_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
      .byte_addr      (addr_q),
      .size           (size_q),
      .next_byte_addr (next_addr),
      .word_addr      (word_addr)
   );

   assign last_beat = (beat_q == len_q);
   assign aw_hs     = (state == ST_IDLE) && bus.awvalid;
   assign ar_hs     = (state == ST_IDLE) && bus.arvalid && !bus.awvalid;
   assign w_hs      = (state == ST_WR_DATA) && bus.wvalid;
   assign r_hs      = (state == ST_RD_RESP) && bus.rready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Next-state logic; writes win over reads when both request in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (bus.awvalid)      next_state = ST_WR_DATA;
            else if (bus.arvalid) next_state = ST_RD_REQ;
         end
         ST_RD_REQ:  next_state = ST_RD_CAP;
         ST_RD_CAP:  next_state = ST_RD_RESP;
         ST_RD_RESP: if (bus.rready) next_state = last_beat ? ST_IDLE : ST_RD_REQ;
         ST_WR_DATA: if (bus.wvalid) next_state = ST_WR_MEM;
         ST_WR_MEM:  next_state = wr_done_q ? ST_WR_RESP : ST_WR_DATA;
         ST_WR_RESP: if (bus.bready) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Transaction context: id/address/length capture, beat counting, data and error tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         wr_done_q <= 1'b0;
         rdata_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         if (aw_hs) begin
            id_q      <= bus.awid;
            addr_q    <= bus.awaddr[ADDR_W+1:0];
            len_q     <= bus.awlen;
            size_q    <= bus.awsize;
            beat_q    <= '0;
            err_q     <= size_err(bus.awsize);
            wr_done_q <= 1'b0;
         end else if (ar_hs) begin
            id_q   <= bus.arid;
            addr_q <= bus.araddr[ADDR_W+1:0];
            len_q  <= bus.arlen;
            size_q <= bus.arsize;
            beat_q <= '0;
            err_q  <= size_err(bus.arsize);
         end
         if (state == ST_RD_CAP) rdata_q <= ram_rdata;
         if (r_hs && !last_beat) begin
            beat_q <= beat_q + 4'd1;
            addr_q <= next_addr;
         end
         // An early or missing wlast ends the burst here and flags SLVERR.
         if (w_hs) begin
            wdata_q   <= bus.wdata;
            wstrb_q   <= bus.wstrb;
            wr_done_q <= bus.wlast || last_beat;
            if (bus.wlast != last_beat) err_q <= 1'b1;
         end
         if ((state == ST_WR_MEM) && !wr_done_q) begin
            beat_q <= beat_q + 4'd1;
            addr_q <= next_addr;
         end
      end
   end

   // Outputs decoded from state and registers; ram_* never see a handshake input directly.
   always_comb begin
      bus.awready = (state == ST_IDLE) && !rst;
      bus.arready = (state == ST_IDLE) && !rst && !bus.awvalid;
      bus.wready  = (state == ST_WR_DATA);
      bus.rvalid  = (state == ST_RD_RESP);
      bus.rid     = id_q;
      bus.rdata   = rdata_q;
      bus.rresp   = ((state == ST_RD_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
      bus.rlast   = (state == ST_RD_RESP) && last_beat;
      bus.bvalid  = (state == ST_WR_RESP);
      bus.bid     = id_q;
      bus.bresp   = ((state == ST_WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
      ram_en      = (state == ST_RD_REQ) || (state == ST_WR_MEM);
      ram_wen     = (state == ST_WR_MEM) ? wstrb_q : 4'b0000;
      ram_addr    = word_addr;
      ram_wdata   = wdata_q;
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - table-driven scoreboard bench for axi_sram_slave
module tb_axi_sram_slave;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ram_en;
   logic [3:0]  ram_wen;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;

   axi_sram_slave_if #(.ID_W(4)) bus ();

   axi_sram_slave #(.ADDR_W(16), .ID_W(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
   typedef struct { logic [15:0] addr; logic [3:0] wen; logic [31:0] data; } wexp_t;
   typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
   typedef struct {
      bit wr; logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [3:0] id;
      logic [31:0] data; logic [3:0] strb; int wlast_beat; logic [1:0] exp_resp;
   } vec_t;

   logic [31:0] sram    [0:65535];
   logic [31:0] exp_mem [0:65535];
   rexp_t rq[$];
   wexp_t wq[$];
   bexp_t bq[$];
   vec_t  vecs [13];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    wr_cnt  = 0;
   bit    rready_hold = 0;
   bit    stall_valid;
   logic [31:0] stall_data;
   logic        stall_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Behavioural synchronous SRAM, one cycle read latency.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wen == 4'b0000) ram_rdata <= sram[ram_addr];
         else for (int i = 0; i < 4; i++)
            if (ram_wen[i]) sram[ram_addr][8*i +: 8] = ram_wdata[8*i +: 8];
      end
   end

   function automatic logic [17:0] adv(input logic [17:0] a, input logic [2:0] s);
      if (s >= 3'd2) return {a[17:2] + 16'd1, 2'b00};
      return a + (18'd1 << s);
   endfunction

   // rready toggles 1/0 every cycle unless a test needs it held low.
   initial begin
      bus.rready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.rready = rready_hold ? 1'b0 : ~bus.rready;
      end
   end

   // Output monitor: pops scoreboard entries on R/B handshakes and SRAM writes.
   initial begin
      rexp_t er; bexp_t eb; wexp_t ew;
      stall_valid = 0;
      forever begin
         @(negedge clk);
         if (rst) stall_valid = 0;
         else begin
            if (bus.rvalid) begin
               if (stall_valid) begin
                  check("r_stable_data", bus.rdata, stall_data);
                  check("r_stable_last", 32'(bus.rlast), 32'(stall_last));
               end
               if (bus.rready) begin
                  stall_valid = 0;
                  if (rq.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL r_unexpected: got beat 0x%h expected none", bus.rdata);
                  end else begin
                     er = rq.pop_front();
                     check("r_id", 32'(bus.rid), 32'(er.id));
                     check("r_data", bus.rdata, er.data);
                     check("r_resp", 32'(bus.rresp), 32'(er.resp));
                     check("r_last", 32'(bus.rlast), 32'(er.last));
                  end
               end else begin
                  stall_valid = 1; stall_data = bus.rdata; stall_last = bus.rlast;
               end
            end
            if (bus.bvalid && bus.bready) begin
               if (bq.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL b_unexpected: got bid %0d expected none", bus.bid);
               end else begin
                  eb = bq.pop_front();
                  check("b_id", 32'(bus.bid), 32'(eb.id));
                  check("b_resp", 32'(bus.bresp), 32'(eb.resp));
               end
            end
            if (ram_en && ram_wen != 4'b0000) begin
               wr_cnt++;
               if (wq.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL ram_unexpected_write: got addr 0x%h expected none", ram_addr);
               end else begin
                  ew = wq.pop_front();
                  check("ram_addr", 32'(ram_addr), 32'(ew.addr));
                  check("ram_wen", 32'(ram_wen), 32'(ew.wen));
                  check("ram_wdata", ram_wdata, ew.data);
               end
            end
         end
      end
   end

   task automatic push_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [3:0] id, input logic [1:0] resp);
      logic [17:0] a = addr[17:0];
      for (int b = 0; b <= int'(len); b++) begin
         rq.push_back('{id, exp_mem[a[17:2]], resp, (b == int'(len))});
         a = adv(a, size);
      end
   endtask

   task automatic wait_q_empty(input string name);
      int t = 0;
      while ((rq.size() + bq.size()) > 0 && t < 300) begin @(posedge clk); t++; end
      check(name, 32'(rq.size() + bq.size()), 32'd0);
      #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [3:0] id, input logic [1:0] resp);
      int lat = 1;
      int t = 0;
      push_read(addr, len, size, id, resp);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!bus.arready && t < 20);
      check("ar_accept", 32'(bus.arready), 32'd1);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.rvalid) break;
         @(posedge clk);
         lat++;
      end
      check("rd_latency", 32'(lat), 32'd3);
      wait_q_empty("rd_done");
   endtask

   task automatic do_write(input vec_t v);
      int beats = (v.wlast_beat < int'(v.len)) ? v.wlast_beat + 1 : int'(v.len) + 1;
      int cnt0 = wr_cnt;
      int t;
      logic [17:0] a = v.addr[17:0];
      logic [31:0] d;
      bq.push_back('{v.id, v.exp_resp});
      for (int b = 0; b < beats; b++) begin
         d = v.data + 32'(b);
         if (v.strb != 4'b0000) wq.push_back('{a[17:2], v.strb, d});
         for (int i = 0; i < 4; i++) if (v.strb[i]) exp_mem[a[17:2]][8*i +: 8] = d[8*i +: 8];
         a = adv(a, v.size);
      end
      bus.awid = v.id; bus.awaddr = v.addr; bus.awlen = v.len; bus.awsize = v.size; bus.awvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
      check("aw_accept", 32'(bus.awready), 32'd1);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      for (int b = 0; b < beats; b++) begin
         bus.wdata = v.data + 32'(b); bus.wstrb = v.strb; bus.wlast = (b == v.wlast_beat);
         bus.wvalid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!bus.wready && t < 20);
         check("w_accept", 32'(bus.wready), 32'd1);
         @(posedge clk); #1;
         bus.wvalid = 1'b0; bus.wlast = 1'b0;
      end
      wait_q_empty("wr_done");
      check("wr_count", 32'(wr_cnt - cnt0), (v.strb != 4'b0000) ? 32'(beats) : 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] k;
      int t;
      bit bad;
      for (int i = 0; i < 65536; i++) begin
         k = i[15:0];
         exp_mem[i] = {~k, k};
         sram[i]    = {~k, k};
      end
      exp_mem[16'h10] = 32'hDEADBEEF; sram[16'h10] = 32'hDEADBEEF;

      bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.wlast = 0; bus.bready = 1;
      bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 2'b01;
      bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 2'b01;
      bus.wdata = 0; bus.wstrb = 0;

      //            wr  addr         len   size  id     data          strb     wl  resp
      vecs[0]  = '{1'b1, 32'h44,    4'd0, 3'd2, 4'd5,  32'h11223344, 4'b0011, 0,  2'b00};
      vecs[1]  = '{1'b0, 32'h44,    4'd0, 3'd2, 4'd5,  32'h0,        4'b0000, 0,  2'b00};
      vecs[2]  = '{1'b0, 32'h40,    4'd0, 3'd2, 4'd3,  32'h0,        4'b0000, 0,  2'b00};
      vecs[3]  = '{1'b0, 32'h100,   4'd3, 3'd2, 4'd1,  32'h0,        4'b0000, 0,  2'b00};
      vecs[4]  = '{1'b1, 32'h200,   4'd3, 3'd2, 4'd2,  32'hA0,       4'b1111, 1,  2'b10};
      vecs[5]  = '{1'b0, 32'h200,   4'd1, 3'd2, 4'd2,  32'h0,        4'b0000, 0,  2'b00};
      vecs[6]  = '{1'b1, 32'h300,   4'd1, 3'd2, 4'd4,  32'hB0,       4'b1111, 15, 2'b10};
      vecs[7]  = '{1'b1, 32'h400,   4'd2, 3'd1, 4'd6,  32'hC0C0C0C0, 4'b1111, 2,  2'b00};
      vecs[8]  = '{1'b0, 32'h400,   4'd2, 3'd1, 4'd6,  32'h0,        4'b0000, 0,  2'b00};
      vecs[9]  = '{1'b0, 32'h500,   4'd0, 3'd3, 4'd7,  32'h0,        4'b0000, 0,  2'b10};
      vecs[10] = '{1'b0, 32'h3FFFC, 4'd1, 3'd2, 4'd8,  32'h0,        4'b0000, 0,  2'b00};
      vecs[11] = '{1'b1, 32'h601,   4'd1, 3'd0, 4'd9,  32'hD0,       4'b0001, 1,  2'b00};
      vecs[12] = '{1'b1, 32'h700,   4'd0, 3'd2, 4'd10, 32'hE0,       4'b0000, 0,  2'b00};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_valids", {29'd0, bus.rvalid, bus.bvalid, bus.wready}, 32'd0);
      check("rst_ram", {11'd0, ram_en, ram_wen, ram_addr}, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_ids_resp", {20'd0, bus.rid, bus.bid, bus.rresp, bus.bresp}, 32'd0);
      check("rst_rlast", 32'(bus.rlast), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) do_write(vecs[i]);
         else do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].id, vecs[i].exp_resp);
      end

      // Simultaneous AR and AW: write first, read held off until the B handshake.
      bq.push_back('{4'd6, 2'b00});
      wq.push_back('{16'h200, 4'b1111, 32'h55667788});
      exp_mem[16'h200] = 32'h55667788;
      bus.awid = 4'd6; bus.awaddr = 32'h800; bus.awlen = 0; bus.awsize = 3'd2; bus.awvalid = 1'b1;
      bus.arid = 4'd7; bus.araddr = 32'h800; bus.arlen = 0; bus.arsize = 3'd2; bus.arvalid = 1'b1;
      @(negedge clk);
      check("pri_awready", 32'(bus.awready), 32'd1);
      check("pri_arready", 32'(bus.arready), 32'd0);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      bus.wdata = 32'h55667788; bus.wstrb = 4'b1111; bus.wlast = 1'b1; bus.wvalid = 1'b1;
      bad = 0; t = 0;
      do begin
         @(negedge clk);
         if (bus.arready) bad = 1;
         if (bus.wready) begin @(posedge clk); #1; bus.wvalid = 1'b0; bus.wlast = 1'b0; end
         t++;
      end while (bq.size() > 0 && t < 50);
      check("pri_ar_held", 32'(bad), 32'd0);
      check("pri_b_done", 32'(bq.size()), 32'd0);
      push_read(32'h800, 4'd0, 3'd2, 4'd7, 2'b00);
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.arready && t < 20);
      check("pri_ar_accept", 32'(bus.arready), 32'd1);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      wait_q_empty("pri_rd_done");

      // Reset while a read response is stalled.
      rready_hold = 1;
      @(posedge clk); #1;
      bus.arid = 4'd3; bus.araddr = 32'h40; bus.arlen = 0; bus.arsize = 3'd2; bus.arvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.arready && t < 20);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.rvalid && t < 20);
      check("rst6_rvalid_before", 32'(bus.rvalid), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      rq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst6_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst6_ram_en", 32'(ram_en), 32'd0);
      check("rst6_idle", 32'(bus.arready), 32'd1);
      rready_hold = 0;
      @(posedge clk); #1;
      do_read(32'h40, 4'd0, 3'd2, 4'd3, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
